// File: rtl/pipe_track.sv
// Pipeline instruction-word tracker: shifts decode/execute/memory/wrback words,
// applies hazard stalls and branch flushes, counts stalls/retires, and latches a stall watchdog fault.
module pipe_track #(
  parameter int STALL_MAX = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr,
  output logic             fetch_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [31:0]      decode,
  output logic [31:0]      execute,
  output logic [31:0]      memory,
  output logic [31:0]      wrback,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] retired_count,
  output logic             stall_err
);

  // state | meaning
  // RUN   | pipeline advancing normally (or just flushed)
  // HOLD  | last edge applied a stall; decode held, bubble injected
  // FAULT | stall persisted STALL_MAX edges; everything frozen until rst
  typedef enum logic [1:0] {RUN, HOLD, FAULT} state_t;

  localparam logic [31:0]      NOP       = 32'h0000_0000;
  localparam logic [7:0]       HOLD_LAST = 8'(STALL_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t     state;
  logic [7:0] hold_cnt;

  assign fetch_ready = !stall && !flush && (state != FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      hold_cnt      <= 8'd0;
      decode        <= NOP;
      execute       <= NOP;
      memory        <= NOP;
      wrback        <= NOP;
      stall_count   <= '0;
      retired_count <= '0;
      stall_err     <= 1'b0;
    end else if (state != FAULT) begin
      wrback <= memory;
      memory <= execute;
      if (wrback != NOP && retired_count != CNT_MAX)
        retired_count <= retired_count + CNT_ONE;

      // flush wins over stall: wrong-path decode word is dropped, not counted as a stall
      if (flush) begin
        execute  <= NOP;
        decode   <= NOP;
        hold_cnt <= 8'd0;
        state    <= RUN;
      end else if (stall) begin
        execute  <= NOP;
        hold_cnt <= hold_cnt + 8'd1;
        if (stall_count != CNT_MAX)
          stall_count <= stall_count + CNT_ONE;
        if (hold_cnt == HOLD_LAST) begin
          state     <= FAULT;
          stall_err <= 1'b1;
        end else begin
          state <= HOLD;
        end
      end else begin
        execute  <= decode;
        decode   <= fetch_valid ? fetch_instr : NOP;
        hold_cnt <= 8'd0;
        state    <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_pipe_track.sv
// Scoreboard bench for pipe_track: directed scenarios plus random traffic, checked
// against a queue-based reference of the pipeline contents and counters.
module tb_pipe_track;
  localparam int SMAX = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_valid = 1'b0;
  logic [31:0]   fetch_instr = '0;
  logic          fetch_ready;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   decode, execute, memory, wrback;
  logic [CW-1:0] stall_count, retired_count;
  logic          stall_err;

  always #5 clk = ~clk;

  pipe_track #(.STALL_MAX(SMAX), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .stall(stall), .flush(flush),
    .decode(decode), .execute(execute), .memory(memory), .wrback(wrback),
    .stall_count(stall_count), .retired_count(retired_count), .stall_err(stall_err)
  );

  typedef struct {
    logic [31:0] d, e, m, w;
    int          sc, rc;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  bit   rdy_q[$];

  int errors = 0;
  int checks = 0;

  // reference: pipe[0]=decode .. pipe[3]=wrback
  logic [31:0] pipe[4];
  int  m_sc, m_rc, m_run;
  bit  m_fault, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    m_sc = 0; m_rc = 0; m_run = 0; m_fault = 0; m_err = 0;
  endtask

  task automatic step(input bit r, input bit fv, input logic [31:0] fi, input bit st, input bit fl);
    exp_t e;
    @(negedge clk);
    rst = r; fetch_valid = fv; fetch_instr = fi; stall = st; flush = fl;
    rdy_q.push_back(!st && !fl && !m_fault);
    if (r) model_reset();
    else if (!m_fault) begin
      if (pipe[3] != 0) m_rc = sat_inc(m_rc);
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      if (fl) begin
        pipe[1] = '0; pipe[0] = '0; m_run = 0;
      end else if (st) begin
        pipe[1] = '0;
        m_sc  = sat_inc(m_sc);
        m_run = m_run + 1;
        if (m_run >= SMAX) begin m_fault = 1; m_err = 1; end
      end else begin
        pipe[1] = pipe[0];
        pipe[0] = fv ? fi : 32'h0;
        m_run = 0;
      end
    end
    e.d = pipe[0]; e.e = pipe[1]; e.m = pipe[2]; e.w = pipe[3];
    e.sc = m_sc; e.rc = m_rc; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    bit r;
    #2;
    if (rdy_q.size() > 0) begin
      r = rdy_q.pop_front();
      check("fetch_ready", {31'b0, fetch_ready}, {31'b0, r});
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("decode", decode, e.d);
      check("execute", execute, e.e);
      check("memory", memory, e.m);
      check("wrback", wrback, e.w);
      check("stall_count", 32'(stall_count), 32'(e.sc));
      check("retired_count", 32'(retired_count), 32'(e.rc));
      check("stall_err", {31'b0, stall_err}, {31'b0, e.err});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit          r, st, fl, pv, ok;
    logic [31:0] pend;
    model_reset();

    // reset and stream
    step(1, 0, 0, 0, 0); after_edge();
    check("rst decode", decode, 0);
    step(1, 0, 0, 0, 0); after_edge();
    check("rst stall_err", {31'b0, stall_err}, 0);
    step(0, 1, 32'h8C220004, 0, 0);
    step(0, 1, 32'h00642820, 0, 0);
    step(0, 1, 32'h20A60001, 0, 0);
    step(0, 0, 0, 0, 0); after_edge();
    check("stream wrback", wrback, 32'h8C220004);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    after_edge();
    check("stream retired", 32'(retired_count), 3);

    // load-use stall
    step(0, 1, 32'h8C220004, 0, 0);
    step(0, 1, 32'h00431020, 0, 0);
    step(0, 1, 32'hAC430008, 1, 0);
    #1 check("loaduse ready", {31'b0, fetch_ready}, 0);
    after_edge();
    check("loaduse decode", decode, 32'h00431020);
    check("loaduse execute", execute, 0);
    check("loaduse memory", memory, 32'h8C220004);
    check("loaduse stall_count", 32'(stall_count), 1);

    // flush with stall
    step(0, 1, 32'h10220003, 0, 0);
    step(0, 1, 32'h12345678, 0, 0);
    step(0, 1, 32'h0000000C, 1, 1); after_edge();
    check("flush decode", decode, 0);
    check("flush execute", execute, 0);
    check("flush memory", memory, 32'h10220003);
    check("flush stall_count", 32'(stall_count), 1);

    // reset mid-stall, hold count must restart
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0); after_edge();
    check("midrst stall_count", 32'(stall_count), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    after_edge();
    check("midrst no fault", {31'b0, stall_err}, 0);
    step(0, 0, 0, 0, 0);

    // watchdog
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h8C220004, 0, 0);
    step(0, 1, 32'h00431020, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    after_edge();
    check("wd err", {31'b0, stall_err}, 1);
    check("wd stall_count", 32'(stall_count), 4);
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'h11111111, 0, 0);
    #1 check("wd ready", {31'b0, fetch_ready}, 0);
    after_edge();
    check("wd frozen decode", decode, 32'h00431020);
    check("wd sticky", {31'b0, stall_err}, 1);
    step(1, 0, 0, 0, 0); after_edge();
    check("wd cleared", {31'b0, stall_err}, 0);
    step(0, 0, 0, 0, 0);
    #1 check("wd ready after rst", {31'b0, fetch_ready}, 1);

    // counter saturation
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 32'h20A60001 + i, 1, 0);
      step(0, 1, 32'h20A60001 + i, 0, 0);
    end
    after_edge();
    check("sat stall_count", 32'(stall_count), 15);
    step(0, 0, 0, 1, 0); after_edge();
    check("sat hold", 32'(stall_count), 15);

    // random traffic
    pv = 0; pend = '0;
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 30);
      fl = ($urandom_range(0, 99) < 10);
      if (!pv) begin
        pv   = ($urandom_range(0, 99) < 70);
        pend = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      end
      ok = pv && !st && !fl && !m_fault && !r;
      step(r, pv, pend, st, fl);
      if (ok) pv = 0;
    end

    @(posedge clk);
    #3;
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
